fetch_stage: RTL and testbench

- IF stage directly upstream of decode. Generates the PC and issues in-order requests on the instruction-SRAM req/addr_ok/data_ok interface.
- Buffers returned instructions and delivers one fs_to_ds_bus_t per cycle under the ds_allowin handshake.
- Handles redirects and flushes, including preservation of the branch delay slot.
- Marks the bd flag and address-error exceptions.

---
 rtl/fetch_stage_pkg.sv | 42 ++++
 rtl/fetch_inst_buffer.sv | 49 ++++
 rtl/fetch_stage.sv | 183 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction fetch stage.
// Bus bundles, exception info, fetch states and branch predecode.
package fetch_stage_pkg;

  localparam logic [4:0] EXCCODE_ADEL = 5'h04;

  typedef struct packed {
    logic        ex;
    logic        bd;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
  } exception_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    exception_t  exception;
  } fs_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    exception_t  exception;
  } fs_to_ds_bus_t;

  typedef enum logic [1:0] {
    RUN,
    WAIT_DS,
    HOLD
  } fetch_state_t;

  function automatic logic predecode_is_branch(
    input logic [31:0] inst
  );
    logic [5:0] op;
    op = inst[31:26];
    return (op inside {[6'h01:6'h07]}) ||
           (op == 6'h00 && inst[5:1] == 5'b00100);
  endfunction

endpackage

// File: rtl/fetch_inst_buffer.sv
// Small circular FIFO with clear and keep-head-only truncation.
// Used for both the instruction buffer and the in-flight pc queue.
module fetch_inst_buffer #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     trunc,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;

  assign dout = mem[rptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (trunc) begin
      wptr  <= rptr + AW'(1);
      count <= (AW+1)'(1);
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push)
                     - (AW+1)'(pop);
    end
  end

  // storage write, no reset needed
  always_ff @(posedge clk) begin
    if (push && !reset && !clear && !trunc)
      mem[wptr] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC generation, SRAM request credit, instruction buffer,
// redirect/flush handling with delay-slot preservation, AdEL marking.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ds_allowin,
  output fs_to_ds_bus_t fs_to_ds_bus,
  output logic          inst_req,
  output logic [31:0]   inst_addr,
  input  logic          inst_addr_ok,
  input  logic          inst_data_ok,
  input  logic [31:0]   inst_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_target,
  input  logic          flush,
  input  logic [31:0]   flush_pc
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [31:0]   saved_pc;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] inflight;
  logic [CW-1:0] count;
  logic [CW-1:0] left;
  logic [CW:0]   occ;
  logic          ds_pending;
  logic          last_is_br;
  fs_entry_t     head;
  fs_entry_t     enq_entry;
  logic [31:0]   rsp_pc;
  logic [31:0]   tgt;
  logic          deq, rsp, rsp_keep, pend;
  logic          flush_like, keep_head, keep_ds;
  logic          can_issue, issue, adel;
  logic          push, pop;

  assign occ        = {1'b0, inflight} + {1'b0, count};
  assign deq        = (count != '0) && ds_allowin;
  assign rsp        = inst_data_ok && (inflight != '0);
  assign rsp_keep   = rsp && (drop_cnt == '0);
  assign pend       = ds_pending && !deq;
  assign flush_like = flush || (redirect_valid && !pend);
  assign keep_head  = !flush && redirect_valid && pend
                      && (count != '0);
  assign keep_ds    = !flush && redirect_valid && pend
                      && (count == '0);
  assign tgt        = flush ? flush_pc : redirect_target;
  assign left       = inflight - CW'(rsp);

  assign can_issue = (state == RUN) ||
                     (state == WAIT_DS && inflight == '0);

  assign inst_req  = !reset && !flush && !redirect_valid
                     && can_issue && pc[1:0] == 2'b00
                     && occ < (CW+1)'(BUF_DEPTH);
  assign inst_addr = pc;
  assign issue     = inst_req && inst_addr_ok;

  assign adel = !reset && !flush && !redirect_valid
                && state == RUN && pc[1:0] != 2'b00
                && inflight == '0
                && count < CW'(BUF_DEPTH);

  // select the entry entering the instruction buffer
  always_comb begin
    enq_entry = '0;
    push      = 1'b0;
    if (!flush_like && !keep_head) begin
      if (rsp_keep) begin
        push                 = 1'b1;
        enq_entry.pc         = rsp_pc;
        enq_entry.inst       = inst_rdata;
        enq_entry.exception.bd = last_is_br;
      end else if (adel) begin
        push                       = 1'b1;
        enq_entry.pc               = pc;
        enq_entry.exception.ex     = 1'b1;
        enq_entry.exception.bd     = last_is_br;
        enq_entry.exception.exccode  = EXCCODE_ADEL;
        enq_entry.exception.badvaddr = pc;
      end
    end
  end

  assign pop = deq && !flush_like;

  fetch_inst_buffer #(
    .DEPTH(BUF_DEPTH),
    .W($bits(fs_entry_t))
  ) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .clear (flush_like),
    .trunc (keep_head),
    .push  (push),
    .din   (enq_entry),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  fetch_inst_buffer #(
    .DEPTH(BUF_DEPTH),
    .W(32)
  ) u_pcq (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .trunc (1'b0),
    .push  (issue),
    .din   (pc),
    .pop   (rsp),
    .dout  (rsp_pc),
    .count (inflight)
  );

  assign fs_to_ds_bus = '{
    valid:     (count != '0),
    pc:        head.pc,
    inst:      head.inst,
    exception: head.exception
  };

  // pc, state, drop accounting and branch tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      saved_pc   <= RESET_PC;
      state      <= RUN;
      drop_cnt   <= '0;
      ds_pending <= 1'b0;
      last_is_br <= 1'b0;
    end else if (flush_like) begin
      pc         <= tgt;
      state      <= RUN;
      drop_cnt   <= left;
      ds_pending <= 1'b0;
      last_is_br <= 1'b0;
    end else if (keep_head) begin
      pc         <= redirect_target;
      state      <= RUN;
      drop_cnt   <= left;
      last_is_br <= 1'b0;
    end else if (keep_ds && !rsp_keep) begin
      saved_pc <= redirect_target;
      state    <= WAIT_DS;
      if (rsp && drop_cnt != '0)
        drop_cnt <= drop_cnt - CW'(1);
    end else if ((keep_ds || state == WAIT_DS)
                 && rsp_keep) begin
      pc         <= keep_ds ? redirect_target
                            : saved_pc;
      state      <= RUN;
      drop_cnt   <= left;
      last_is_br <= predecode_is_branch(inst_rdata);
    end else begin
      if (issue) begin
        if (state == WAIT_DS) begin
          pc    <= saved_pc;
          state <= RUN;
        end else begin
          pc <= pc + 32'd4;
        end
      end
      if (adel) state <= HOLD;
      if (rsp && drop_cnt != '0)
        drop_cnt <= drop_cnt - CW'(1);
      if (push)
        last_is_br <= predecode_is_branch(enq_entry.inst);
      if (deq)
        ds_pending <= predecode_is_branch(head.inst);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order SRAM model.
// Scenario tasks check delivered entries against hand-derived values.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          ds_allowin;
  fs_to_ds_bus_t fs_to_ds_bus;
  logic          inst_req;
  logic [31:0]   inst_addr;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [31:0]   inst_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_target;
  logic          flush;
  logic [31:0]   flush_pc;

  int vectors = 0;
  int miscompares = 0;
  int issued = 0;
  logic resp_en;
  logic [31:0] q[$];
  fs_to_ds_bus_t dlog[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .flush           (flush),
    .flush_pc        (flush_pc)
  );

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    if (a == 32'h100) return 32'h1000_0010;
    return {16'h2400, a[15:0]};
  endfunction

  function automatic fs_to_ds_bus_t get_log(input int i);
    if (i < dlog.size()) return dlog[i];
    return '0;
  endfunction

  task automatic tick();
    inst_data_ok = resp_en && (q.size() > 0);
    inst_rdata = (q.size() > 0) ? mem_word(q[0]) : 32'h0;
    #1;
    if (fs_to_ds_bus.valid && ds_allowin)
      dlog.push_back(fs_to_ds_bus);
    if (inst_req && inst_addr_ok) begin
      q.push_back(inst_addr);
      issued++;
    end
    if (inst_data_ok) void'(q.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ds_allowin = 1'b0;
    inst_addr_ok = 1'b0;
    resp_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    flush = 1'b0;
    flush_pc = '0;
    tick();
    tick();
    q.delete();
    dlog.delete();
    issued = 0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ds_allowin = 1'b1;
    inst_addr_ok = 1'b1;
    resp_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    flush = 1'b0;
    flush_pc = '0;
    tick();
    tick();
    vectors++;
    if (inst_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_req: got %b want 0", inst_req);
    end
    vectors++;
    if (fs_to_ds_bus.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_valid: got %b want 0",
               fs_to_ds_bus.valid);
    end
    q.delete();
    dlog.delete();
    issued = 0;
    reset = 1'b0;
    #1;
    vectors++;
    if (inst_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_req_after: got %b want 1", inst_req);
    end
    vectors++;
    if (inst_addr !== 32'hBFC0_0000) begin
      miscompares++;
      $display("FAIL rst_pc: got %h want bfc00000", inst_addr);
    end
  endtask

  task automatic test_sequential();
    fs_to_ds_bus_t e;
    do_reset();
    ds_allowin = 1'b1;
    inst_addr_ok = 1'b1;
    resp_en = 1'b1;
    tick();
    vectors++;
    if (fs_to_ds_bus.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_lat0: got %b want 0",
               fs_to_ds_bus.valid);
    end
    tick();
    vectors++;
    if (fs_to_ds_bus.valid !== 1'b1 ||
        fs_to_ds_bus.pc !== 32'hBFC0_0000) begin
      miscompares++;
      $display("FAIL seq_lat1: got v=%b pc=%h want v=1 pc=bfc00000",
               fs_to_ds_bus.valid, fs_to_ds_bus.pc);
    end
    repeat (8) tick();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ep;
      ep = 32'hBFC0_0000 + 32'(4 * i);
      e = get_log(i);
      vectors++;
      if (e.valid !== 1'b1 || e.pc !== ep ||
          e.inst !== mem_word(ep) ||
          e.exception.bd !== 1'b0 ||
          e.exception.ex !== 1'b0) begin
        miscompares++;
        $display("FAIL seq_%0d: got pc=%h inst=%h bd=%b ex=%b want pc=%h inst=%h bd=0 ex=0",
                 i, e.pc, e.inst, e.exception.bd,
                 e.exception.ex, ep, mem_word(ep));
      end
    end
  endtask

  task automatic test_stall();
    fs_to_ds_bus_t e;
    do_reset();
    ds_allowin = 1'b1;
    inst_addr_ok = 1'b1;
    resp_en = 1'b1;
    repeat (4) tick();
    ds_allowin = 1'b0;
    repeat (10) tick();
    vectors++;
    if (issued - dlog.size() != 4) begin
      miscompares++;
      $display("FAIL stall_occ: got %0d want 4",
               issued - dlog.size());
    end
    vectors++;
    if (inst_req !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_req: got %b want 0", inst_req);
    end
    ds_allowin = 1'b1;
    repeat (12) tick();
    vectors++;
    if (dlog.size() < 12) begin
      miscompares++;
      $display("FAIL stall_cnt: got %0d want >=12", dlog.size());
    end
    for (int i = 0; i < dlog.size(); i++) begin
      logic [31:0] ep;
      ep = 32'hBFC0_0000 + 32'(4 * i);
      e = dlog[i];
      vectors++;
      if (e.pc !== ep || e.inst !== mem_word(ep)) begin
        miscompares++;
        $display("FAIL stall_seq_%0d: got pc=%h want %h",
                 i, e.pc, ep);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    ds_allowin = 1'b1;
    inst_addr_ok = 1'b1;
    resp_en = 1'b0;
    tick();
    tick();
    vectors++;
    if (q.size() != 2) begin
      miscompares++;
      $display("FAIL flush_inflight: got %0d want 2", q.size());
    end
    flush = 1'b1;
    flush_pc = 32'hBFC0_0380;
    #1;
    vectors++;
    if (inst_req !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_req: got %b want 0", inst_req);
    end
    tick();
    flush = 1'b0;
    resp_en = 1'b1;
    repeat (8) tick();
    vectors++;
    if (get_log(0).pc !== 32'hBFC0_0380) begin
      miscompares++;
      $display("FAIL flush_pc0: got %h want bfc00380",
               get_log(0).pc);
    end
    vectors++;
    if (get_log(1).pc !== 32'hBFC0_0384) begin
      miscompares++;
      $display("FAIL flush_pc1: got %h want bfc00384",
               get_log(1).pc);
    end
  endtask

  task automatic test_delay_slot();
    fs_to_ds_bus_t e;
    logic seen;
    do_reset();
    ds_allowin = 1'b1;
    inst_addr_ok = 1'b1;
    resp_en = 1'b0;
    flush = 1'b1;
    flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    tick();
    resp_en = 1'b1;
    tick();
    resp_en = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    resp_en = 1'b1;
    repeat (6) tick();
    e = get_log(0);
    vectors++;
    if (e.pc !== 32'h100 || e.exception.bd !== 1'b0) begin
      miscompares++;
      $display("FAIL ds_br: got pc=%h bd=%b want pc=100 bd=0",
               e.pc, e.exception.bd);
    end
    e = get_log(1);
    vectors++;
    if (e.pc !== 32'h104 || e.exception.bd !== 1'b1 ||
        e.inst !== mem_word(32'h104)) begin
      miscompares++;
      $display("FAIL ds_slot: got pc=%h bd=%b want pc=104 bd=1",
               e.pc, e.exception.bd);
    end
    e = get_log(2);
    vectors++;
    if (e.pc !== 32'h200 || e.exception.bd !== 1'b0) begin
      miscompares++;
      $display("FAIL ds_target: got pc=%h bd=%b want pc=200 bd=0",
               e.pc, e.exception.bd);
    end
    seen = 1'b0;
    foreach (dlog[i]) if (dlog[i].pc == 32'h108) seen = 1'b1;
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL ds_no108: got %b want 0", seen);
    end
  endtask

  task automatic test_adel();
    fs_to_ds_bus_t e;
    do_reset();
    ds_allowin = 1'b1;
    inst_addr_ok = 1'b1;
    resp_en = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h202;
    tick();
    redirect_valid = 1'b0;
    repeat (4) tick();
    vectors++;
    if (dlog.size() != 1) begin
      miscompares++;
      $display("FAIL adel_cnt: got %0d want 1", dlog.size());
    end
    e = get_log(0);
    vectors++;
    if (e.pc !== 32'h202 || e.inst !== 32'h0) begin
      miscompares++;
      $display("FAIL adel_pc: got pc=%h inst=%h want 202/0",
               e.pc, e.inst);
    end
    vectors++;
    if (e.exception.ex !== 1'b1 ||
        e.exception.exccode !== 5'h04 ||
        e.exception.badvaddr !== 32'h202) begin
      miscompares++;
      $display("FAIL adel_ex: got ex=%b code=%h bad=%h want 1/04/202",
               e.exception.ex, e.exception.exccode,
               e.exception.badvaddr);
    end
    vectors++;
    if (issued != 0 || inst_req !== 1'b0) begin
      miscompares++;
      $display("FAIL adel_hold: got issued=%0d req=%b want 0/0",
               issued, inst_req);
    end
    flush = 1'b1;
    flush_pc = 32'hBFC0_0380;
    tick();
    flush = 1'b0;
    #1;
    vectors++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0380) begin
      miscompares++;
      $display("FAIL adel_resume: got req=%b addr=%h want 1/bfc00380",
               inst_req, inst_addr);
    end
  endtask

  task automatic test_flush_redirect();
    logic seen;
    do_reset();
    ds_allowin = 1'b1;
    inst_addr_ok = 1'b1;
    resp_en = 1'b1;
    repeat (3) tick();
    flush = 1'b1;
    flush_pc = 32'hBFC0_0380;
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    tick();
    flush = 1'b0;
    redirect_valid = 1'b0;
    dlog.delete();
    repeat (8) tick();
    vectors++;
    if (get_log(0).pc !== 32'hBFC0_0380) begin
      miscompares++;
      $display("FAIL fr_pc0: got %h want bfc00380",
               get_log(0).pc);
    end
    vectors++;
    if (get_log(1).pc !== 32'hBFC0_0384) begin
      miscompares++;
      $display("FAIL fr_pc1: got %h want bfc00384",
               get_log(1).pc);
    end
    seen = 1'b0;
    foreach (dlog[i]) if (dlog[i].pc == 32'h200) seen = 1'b1;
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL fr_no200: got %b want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_flush();
    test_delay_slot();
    test_adel();
    test_flush_redirect();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
